// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// spi_bus_arbiter: shares one SPI bus between NUM_MASTERS SPI master cores
// using software-select or round-robin arbitration.  Rev 1.0
// ============================================================================
module spi_bus_arbiter #(
    parameter int   NUM_MASTERS  = 2,
    parameter int   SEL_W        = 3,
    parameter int   SS_W         = 3,
    parameter int   GUARD_CYCLES = 4,
    parameter logic CPOL         = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sw_sel,
    input  logic [NUM_MASTERS-1:0]      m_req,
    output logic [NUM_MASTERS-1:0]      m_gnt,
    input  logic [NUM_MASTERS-1:0]      m_sclk,
    input  logic [NUM_MASTERS-1:0]      m_mosi,
    output logic [NUM_MASTERS-1:0]      m_miso,
    input  logic [NUM_MASTERS*SS_W-1:0] m_ss_n,
    output logic                        spi_sclk,
    output logic                        spi_mosi,
    input  logic                        spi_miso,
    output logic [NUM_MASTERS*SS_W-1:0] spi_ss_n,
    output logic [SEL_W-1:0]            owner,
    output logic                        owner_vld,
    output logic [NUM_MASTERS-1:0]      blocked,
    input  logic                        blocked_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_MASTERS - 1);
    localparam logic [SEL_W:0]   NUM_SEL  = (SEL_W+1)'(NUM_MASTERS);
    localparam logic [7:0]       GUARD_LD = 8'(GUARD_CYCLES);

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         owner_q, owner_d;
    logic [SEL_W-1:0]         last_q, last_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0]   blocked_q, blocked_d;

    logic                     own_ss_idle;
    logic                     own_req;
    logic                     rr_found;
    logic [SEL_W-1:0]         rr_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            blocked_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
        end
    end

    assign owner_vld = (state_q == S_OWNED);
    assign owner     = owner_q;
    assign blocked   = blocked_q;

    always_comb begin
        own_ss_idle = 1'b1;
        own_req     = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == SEL_W'(i)) begin
                own_ss_idle = &m_ss_n[i*SS_W +: SS_W];
                own_req     = m_req[i];
            end
        end
    end

    // Round-robin search starts just after the last released owner.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!rr_found && m_req[i] &&
                    ((int'(last_q) + k == i) || (int'(last_q) + k - NUM_MASTERS == i))) begin
                    rr_found = 1'b1;
                    rr_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!mode) begin
                    if ({1'b0, sw_sel} < NUM_SEL) begin
                        owner_d = sw_sel;
                        state_d = S_OWNED;
                    end
                end else if (rr_found) begin
                    owner_d = rr_idx;
                    state_d = S_OWNED;
                end
            end
            S_OWNED: begin
                if (own_ss_idle && (mode ? !own_req : (sw_sel != owner_q))) begin
                    last_d = owner_q;
                    if (GUARD_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GUARD;
                        cnt_d   = GUARD_LD;
                    end
                end
            end
            S_GUARD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_gnt    = '0;
        m_miso   = '0;
        spi_sclk = CPOL;
        spi_mosi = 1'b0;
        spi_ss_n = '1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_vld && (owner_q == SEL_W'(i))) begin
                m_gnt[i]                  = 1'b1;
                m_miso[i]                 = spi_miso;
                spi_sclk                  = m_sclk[i];
                spi_mosi                  = m_mosi[i];
                spi_ss_n[i*SS_W +: SS_W]  = m_ss_n[i*SS_W +: SS_W];
            end
        end
    end

    // A new violation in the same cycle takes priority over the clear.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            blocked_d[i] = (!(&m_ss_n[i*SS_W +: SS_W]) && !m_gnt[i]) ||
                           (blocked_q[i] && !blocked_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_bus_arbiter: directed checks of spi_bus_arbiter in a 2-master,
// guarded configuration and a 4-master, zero-guard round-robin configuration.
// ============================================================================
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Instance A: 2 masters, GUARD_CYCLES=4
    logic       mode_a = 1'b0;
    logic [2:0] sw_sel_a = 3'd1;
    logic [1:0] m_req_a = '0;
    logic [1:0] m_gnt_a;
    logic [1:0] m_sclk_a = '0;
    logic [1:0] m_mosi_a = '0;
    logic [1:0] m_miso_a;
    logic [5:0] m_ss_n_a = 6'h3F;
    logic       spi_sclk_a, spi_mosi_a;
    logic       spi_miso_a = 1'b0;
    logic [5:0] spi_ss_n_a;
    logic [2:0] owner_a;
    logic       owner_vld_a;
    logic [1:0] blocked_a;
    logic       blocked_clr_a = 1'b0;

    // Instance B: 4 masters, GUARD_CYCLES=0, round-robin
    logic        mode_b = 1'b1;
    logic [1:0]  sw_sel_b = '0;
    logic [3:0]  m_req_b = '0;
    logic [3:0]  m_gnt_b;
    logic [3:0]  m_sclk_b = '0;
    logic [3:0]  m_mosi_b = '0;
    logic [3:0]  m_miso_b;
    logic [11:0] m_ss_n_b = 12'hFFF;
    logic        spi_sclk_b, spi_mosi_b;
    logic        spi_miso_b = 1'b0;
    logic [11:0] spi_ss_n_b;
    logic [1:0]  owner_b;
    logic        owner_vld_b;
    logic [3:0]  blocked_b;
    logic        blocked_clr_b = 1'b0;

    spi_bus_arbiter #(.NUM_MASTERS(2), .SEL_W(3), .SS_W(3), .GUARD_CYCLES(4), .CPOL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .mode(mode_a), .sw_sel(sw_sel_a), .m_req(m_req_a),
        .m_gnt(m_gnt_a), .m_sclk(m_sclk_a), .m_mosi(m_mosi_a), .m_miso(m_miso_a),
        .m_ss_n(m_ss_n_a), .spi_sclk(spi_sclk_a), .spi_mosi(spi_mosi_a),
        .spi_miso(spi_miso_a), .spi_ss_n(spi_ss_n_a), .owner(owner_a),
        .owner_vld(owner_vld_a), .blocked(blocked_a), .blocked_clr(blocked_clr_a)
    );

    spi_bus_arbiter #(.NUM_MASTERS(4), .SEL_W(2), .SS_W(3), .GUARD_CYCLES(0), .CPOL(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .mode(mode_b), .sw_sel(sw_sel_b), .m_req(m_req_b),
        .m_gnt(m_gnt_b), .m_sclk(m_sclk_b), .m_mosi(m_mosi_b), .m_miso(m_miso_b),
        .m_ss_n(m_ss_n_b), .spi_sclk(spi_sclk_b), .spi_mosi(spi_mosi_b),
        .spi_miso(spi_miso_b), .spi_ss_n(spi_ss_n_b), .owner(owner_b),
        .owner_vld(owner_vld_b), .blocked(blocked_b), .blocked_clr(blocked_clr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (spi_sclk_a !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", spi_sclk_a); else pass_cnt++;
        total_cnt++; if (spi_ss_n_a !== 6'h3F) $display("FAIL reset_ss_n: got %b expected 111111", spi_ss_n_a); else pass_cnt++;
        total_cnt++; if (m_gnt_a !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", m_gnt_a); else pass_cnt++;
        total_cnt++; if ({owner_vld_a, owner_a, blocked_a} !== 6'b0) $display("FAIL reset_state: got vld=%b owner=%0d blocked=%b expected all 0", owner_vld_a, owner_a, blocked_a); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        step();
        total_cnt++; if (m_gnt_a !== 2'b10) $display("FAIL release_grant: got %b expected 10", m_gnt_a); else pass_cnt++;
        total_cnt++; if (owner_a !== 3'd1 || owner_vld_a !== 1'b1) $display("FAIL release_owner: got owner=%0d vld=%b expected 1/1", owner_a, owner_vld_a); else pass_cnt++;
    endtask

    task automatic test_mode0_switch();
        int n;
        m_ss_n_a = 6'b110_111;
        sw_sel_a = 3'd0;
        repeat (3) step();
        total_cnt++; if (owner_a !== 3'd1 || m_gnt_a !== 2'b10) $display("FAIL hold_owner: got owner=%0d gnt=%b expected 1/10", owner_a, m_gnt_a); else pass_cnt++;
        total_cnt++; if (spi_ss_n_a !== 6'b110_111) $display("FAIL hold_ss_pass: got %b expected 110111", spi_ss_n_a); else pass_cnt++;
        m_ss_n_a = 6'h3F;
        step();
        total_cnt++; if (m_gnt_a !== 2'b00 || spi_ss_n_a !== 6'h3F) $display("FAIL release_park: got gnt=%b ss=%b expected 00/111111", m_gnt_a, spi_ss_n_a); else pass_cnt++;
        n = 1;
        while (m_gnt_a === 2'b00 && n < 20) begin
            step();
            if (m_gnt_a === 2'b00) n++;
        end
        total_cnt++; if (n !== 5) $display("FAIL guard_gap: got %0d parked cycles expected 5", n); else pass_cnt++;
        total_cnt++; if (m_gnt_a !== 2'b01 || owner_a !== 3'd0) $display("FAIL switch_grant: got gnt=%b owner=%0d expected 01/0", m_gnt_a, owner_a); else pass_cnt++;
    endtask

    task automatic test_collision();
        m_ss_n_a = 6'b110_111;
        #1;
        total_cnt++; if (spi_ss_n_a !== 6'h3F) $display("FAIL collide_gate: got %b expected 111111", spi_ss_n_a); else pass_cnt++;
        step();
        m_ss_n_a = 6'h3F;
        total_cnt++; if (blocked_a !== 2'b10) $display("FAIL collide_flag: got %b expected 10", blocked_a); else pass_cnt++;
        total_cnt++; if (m_gnt_a !== 2'b01) $display("FAIL collide_owner: got %b expected 01", m_gnt_a); else pass_cnt++;
        blocked_clr_a = 1'b1;
        step();
        blocked_clr_a = 1'b0;
        total_cnt++; if (blocked_a !== 2'b00) $display("FAIL blocked_clr: got %b expected 00", blocked_a); else pass_cnt++;
        blocked_clr_a = 1'b1;
        m_ss_n_a = 6'b110_111;
        step();
        blocked_clr_a = 1'b0;
        m_ss_n_a = 6'h3F;
        total_cnt++; if (blocked_a !== 2'b10) $display("FAIL set_over_clr: got %b expected 10", blocked_a); else pass_cnt++;
        blocked_clr_a = 1'b1;
        step();
        blocked_clr_a = 1'b0;
    endtask

    task automatic test_datapath();
        int n;
        sw_sel_a = 3'd1;
        step();
        m_sclk_a = 2'b11;
        m_mosi_a = 2'b11;
        spi_miso_a = 1'b1;
        #1;
        total_cnt++; if ({spi_sclk_a, spi_mosi_a, m_miso_a} !== 4'b0000) $display("FAIL parked_dp: got sclk=%b mosi=%b miso=%b expected 0/0/00", spi_sclk_a, spi_mosi_a, m_miso_a); else pass_cnt++;
        n = 0;
        while (m_gnt_a !== 2'b10 && n < 20) begin
            step();
            n++;
        end
        total_cnt++; if (m_gnt_a !== 2'b10) $display("FAIL dp_grant: got %b expected 10", m_gnt_a); else pass_cnt++;
        m_sclk_a = 2'b10;
        m_mosi_a = 2'b10;
        #1;
        total_cnt++; if ({spi_sclk_a, spi_mosi_a, m_miso_a} !== 4'b1110) $display("FAIL dp_follow1: got sclk=%b mosi=%b miso=%b expected 1/1/10", spi_sclk_a, spi_mosi_a, m_miso_a); else pass_cnt++;
        m_sclk_a = 2'b01;
        m_mosi_a = 2'b01;
        #1;
        total_cnt++; if ({spi_sclk_a, spi_mosi_a} !== 2'b00) $display("FAIL dp_ignore0: got sclk=%b mosi=%b expected 0/0", spi_sclk_a, spi_mosi_a); else pass_cnt++;
        m_sclk_a = '0;
        m_mosi_a = '0;
        spi_miso_a = 1'b0;
        step();
    endtask

    task automatic test_sw_invalid();
        sw_sel_a = 3'd5;
        step();
        repeat (10) step();
        total_cnt++; if (m_gnt_a !== 2'b00 || owner_vld_a !== 1'b0) $display("FAIL sel_out_of_range: got gnt=%b vld=%b expected 00/0", m_gnt_a, owner_vld_a); else pass_cnt++;
        sw_sel_a = 3'd1;
        step();
        total_cnt++; if (m_gnt_a !== 2'b10) $display("FAIL idle_latency: got %b expected 10", m_gnt_a); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        total_cnt++; if (m_gnt_b !== 4'b0000) $display("FAIL rr_no_req: got %b expected 0000", m_gnt_b); else pass_cnt++;
        m_req_b = 4'hF;
        step();
        for (int n = 0; n < 5; n++) begin
            total_cnt++; if (m_gnt_b !== (4'b0001 << exp_order[n]) || owner_b !== 2'(exp_order[n]))
                $display("FAIL rr_grant%0d: got gnt=%b owner=%0d expected owner %0d", n, m_gnt_b, owner_b, exp_order[n]); else pass_cnt++;
            m_req_b[exp_order[n]] = 1'b0;
            step();
            total_cnt++; if (m_gnt_b !== 4'b0000) $display("FAIL rr_idle%0d: got %b expected 0000", n, m_gnt_b); else pass_cnt++;
            m_req_b[exp_order[n]] = 1'b1;
            step();
        end
        m_req_b = '0;
    endtask

    task automatic test_async_reset();
        m_ss_n_a = 6'b110_111;
        #2;
        total_cnt++; if (spi_ss_n_a !== 6'b110_111) $display("FAIL active_ss: got %b expected 110111", spi_ss_n_a); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (owner_vld_a !== 1'b0 || m_gnt_a !== 2'b00 || spi_ss_n_a !== 6'h3F)
            $display("FAIL async_park: got vld=%b gnt=%b ss=%b expected 0/00/111111", owner_vld_a, m_gnt_a, spi_ss_n_a); else pass_cnt++;
        step();
        total_cnt++; if (blocked_a !== 2'b00) $display("FAIL reset_blocked: got %b expected 00", blocked_a); else pass_cnt++;
        m_ss_n_a = 6'h3F;
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_mode0_switch();
        test_collision();
        test_datapath();
        test_sw_invalid();
        test_round_robin();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (SCLK/MOSI/MISO plus chip selects) among NUM_MASTERS Avalon SPI master cores; today that is the ADC and CAN SPI cores on GPIO_0.
- Replaces the single-bit PIO select mux with a registered arbiter that has two modes: software-select and round-robin request/grant.
- Never switches owner while a chip select is active and inserts a guard gap between owners.
- Gates chip selects of non-owners and flags masters that attempted a transfer without a grant.

Parameters:
- NUM_MASTERS, 2, number of SPI master channels (2..8).
- SEL_W, 3, width of sw_sel/owner; must satisfy 2**SEL_W >= NUM_MASTERS.
- SS_W, 3, chip-select lines per master.
- GUARD_CYCLES, 4, idle clk cycles between release and next grant (0..255).
- CPOL, 0, parked level of spi_sclk.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  asynchronous active-low reset.
- mode  in  1  0 = software select, 1 = round-robin on m_req.
- sw_sel  in  SEL_W  requested owner in mode 0 (from PIO).
- m_req  in  NUM_MASTERS  per-master bus request (mode 1 only).
- m_gnt  out  NUM_MASTERS  one-hot grant.
- m_sclk  in  NUM_MASTERS  per-master SCLK.
- m_mosi  in  NUM_MASTERS  per-master MOSI.
- m_miso  out  NUM_MASTERS  per-master MISO return.
- m_ss_n  in  NUM_MASTERS*SS_W  per-master chip selects; master i occupies bits [i*SS_W +: SS_W].
- spi_sclk  out  1  physical SCLK.
- spi_mosi  out  1  physical MOSI.
- spi_miso  in  1  physical MISO.
- spi_ss_n  out  NUM_MASTERS*SS_W  physical chip selects.
- owner  out  SEL_W  current owner index.
- owner_vld  out  1  bus currently granted.
- blocked  out  NUM_MASTERS  sticky flag: master drove ss_n low without a grant.
- blocked_clr  in  1  clears all blocked bits.

Behaviour:
- Reset (async assert, sync release): state IDLE; owner=0; owner_vld=0; m_gnt=0; blocked=0; guard counter=0; rr pointer last=NUM_MASTERS-1.
- FSM IDLE:
  - mode 0: if sw_sel < NUM_MASTERS, go to OWNED with owner=sw_sel on the next edge. If sw_sel >= NUM_MASTERS, stay IDLE.
  - mode 1: pick the first asserted m_req searching last+1, last+2, … (mod NUM_MASTERS), then go to OWNED. With no requests, stay IDLE.
  - Grant latency: exactly 1 cycle from the qualifying input to m_gnt/owner_vld high.
- FSM OWNED:
  - Release condition: all owner ss_n bits high AND (mode 0: sw_sel != owner; mode 1: m_req[owner]==0).
  - On release, go to GUARD with counter=GUARD_CYCLES, clear m_gnt/owner_vld, and set last=owner. If GUARD_CYCLES==0, go directly to IDLE.
  - While any owner ss_n bit is low, the owner is never revoked, regardless of mode, sw_sel or m_req changes.
- FSM GUARD: decrement each cycle; at counter==1, go to IDLE. The bus stays parked throughout.
- Datapath (combinational from registered state):
  - owner_vld=1: spi_sclk=m_sclk[owner]; spi_mosi=m_mosi[owner]; spi_ss_n owner slice = m_ss_n owner slice; all other slices = all 1s; m_miso[owner]=spi_miso; other m_miso=0.
  - owner_vld=0 (parked): spi_sclk=CPOL; spi_mosi=0; spi_ss_n all 1s; m_miso all 0.
- blocked[i]:
  - Sets on any cycle where a bit of m_ss_n slice i is low and NOT (owner_vld && owner==i).
  - Cleared by blocked_clr. A set condition in the same cycle wins over the clear.
- Mode change mid-ownership takes effect only at the next IDLE arbitration.
- m_gnt is always one-hot or zero and equals owner_vld << owner.

Test Plan:
- Reset/park: hold rst=0 with mode=0, sw_sel=1 -> spi_sclk=CPOL(0), spi_ss_n=6'b111111, m_gnt=0. Release rst -> m_gnt=2'b10 after 1 cycle.
- Mode 0 switch: owner=1 with m_ss_n[5:3]=3'b110 active; change sw_sel=0 -> owner stays 1 until ss_n returns to 3'b111. Then 4 cycles parked, 1 cycle IDLE, then m_gnt=2'b01.
- Round-robin (NUM_MASTERS=4, mode=1): m_req=4'b1111 held, each owner drops req after one idle cycle -> grant order 0,1,2,3,0.
- Collision: owner=0, master 1 drives m_ss_n[3]=0 for 1 cycle -> spi_ss_n[5:3] stays 3'b111 and blocked=2'b10. Pulse blocked_clr -> 0. Clear coinciding with a new violation -> stays 1.
- Data path: owner=1, toggle m_sclk[1] and m_mosi[1], drive spi_miso=1 -> spi_sclk/spi_mosi follow master 1, m_miso=2'b10. m_sclk[0] activity produces no output change.
- GUARD_CYCLES=0 and mid-transfer async reset: release goes to IDLE with no gap. rst asserted while owner_vld=1 -> same-cycle park, all ss_n high.
